// File: rtl/hall_input_filter_pkg.sv
// Shared HALL types and helpers: the legal sector sequence and code classification.
package hall_input_filter_pkg;

  typedef logic [2:0] hall_states_t;

  localparam hall_states_t HALL_ILLEGAL_LO = 3'b000;
  localparam hall_states_t HALL_ILLEGAL_HI = 3'b111;

  // Forward rotation: 001 -> 101 -> 100 -> 110 -> 010 -> 011 -> 001
  function automatic hall_states_t hall_next(input hall_states_t s);
    case (s)
      3'b001:  hall_next = 3'b101;
      3'b101:  hall_next = 3'b100;
      3'b100:  hall_next = 3'b110;
      3'b110:  hall_next = 3'b010;
      3'b010:  hall_next = 3'b011;
      3'b011:  hall_next = 3'b001;
      default: hall_next = s;
    endcase
  endfunction

  function automatic hall_states_t hall_prev(input hall_states_t s);
    case (s)
      3'b101:  hall_prev = 3'b001;
      3'b100:  hall_prev = 3'b101;
      3'b110:  hall_prev = 3'b100;
      3'b010:  hall_prev = 3'b110;
      3'b011:  hall_prev = 3'b010;
      3'b001:  hall_prev = 3'b011;
      default: hall_prev = s;
    endcase
  endfunction

  function automatic logic hall_is_legal(input hall_states_t s);
    hall_is_legal = (s != HALL_ILLEGAL_LO) && (s != HALL_ILLEGAL_HI);
  endfunction

  function automatic logic hall_is_adjacent(input hall_states_t a, input hall_states_t b);
    hall_is_adjacent = hall_is_legal(a) && hall_is_legal(b) &&
                       ((b == hall_next(a)) || (b == hall_prev(a)));
  endfunction

endpackage

// File: rtl/hall_input_filter_bit_synchronizer.sv
// Multi-flop synchroniser for an asynchronous bus; index 0 is the capture stage.
module bit_synchronizer #(
  parameter int STAGES = 2,
  parameter int WIDTH  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [STAGES-1:0][WIDTH-1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sync <= '0;
    else        r_sync <= {r_sync[STAGES-2:0], i_d};
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/hall_input_filter.sv
// HALL sensor conditioning: synchronise, debounce, reject illegal codes, flag skips,
// raise a sticky fault on persistent illegal codes and count rejected glitches.
module hall_input_filter
  import hall_input_filter_pkg::*;
#(
  parameter int clk_freq_hz           = 27_000_000,
  parameter int sync_stages           = 2,
  parameter int debounce_ticks        = clk_freq_hz / 1_000_000,
  parameter int invalid_timeout_ticks = clk_freq_hz / 1_000,
  parameter int glitch_count_width    = 16
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [2:0]                    hall_raw,
  input  logic                          fault_clear,
  output hall_states_t                  hall_values,
  output logic                          hall_valid,
  output logic                          hall_changed,
  output logic                          hall_skip,
  output logic                          hall_fault,
  output logic [glitch_count_width-1:0] glitch_count
);

  localparam int DB_W   = $clog2(debounce_ticks + 1);
  localparam int TO_W   = $clog2(invalid_timeout_ticks + 1);
  localparam int WARM_W = $clog2(sync_stages + 1);
  localparam logic [DB_W-1:0]   DB_MAX   = DB_W'(debounce_ticks);
  localparam logic [DB_W-1:0]   DB_ACC   = DB_W'(debounce_ticks - 1);
  localparam logic [TO_W-1:0]   TO_MAX   = TO_W'(invalid_timeout_ticks);
  localparam logic [WARM_W-1:0] WARM_MAX = WARM_W'(sync_stages);

  logic [2:0]                    w_synced;
  logic [WARM_W-1:0]             r_warm;
  hall_states_t                  r_cand;
  hall_states_t                  r_accepted;
  logic [DB_W-1:0]               r_count;
  hall_states_t                  r_values;
  logic                          r_valid;
  logic                          r_changed;
  logic                          r_skip;
  logic                          r_have_legal;
  logic                          r_illegal;
  logic [TO_W-1:0]               r_timer;
  logic                          r_fault;
  logic [glitch_count_width-1:0] r_glitch;

  bit_synchronizer #(
    .STAGES (sync_stages),
    .WIDTH  (3)
  ) u_sync (
    .clk   (clk),
    .rst_n (reset_n),
    .i_d   (hall_raw),
    .o_q   (w_synced)
  );

  // The synchroniser resets to 000; holding the debouncer off until it has refilled
  // keeps that artefact from being seen as a 000 pulse and counted as a glitch.
  logic            w_ready, w_differ, w_accept, w_cand_legal, w_changed, w_skip;
  logic            w_glitch, w_timeout;
  logic [TO_W-1:0] w_timer_inc;

  assign w_ready      = (r_warm == WARM_MAX);
  assign w_differ     = w_ready && (w_synced != r_cand);
  assign w_accept     = w_ready && !w_differ && (r_count == DB_ACC) && (r_cand != r_accepted);
  assign w_cand_legal = hall_is_legal(r_cand);
  assign w_changed    = w_accept && w_cand_legal && (r_cand != r_values);
  assign w_skip       = w_changed && r_have_legal && !hall_is_adjacent(r_values, r_cand);
  assign w_glitch     = w_differ && (r_cand != r_accepted);
  assign w_timer_inc  = (r_timer == TO_MAX) ? r_timer : r_timer + 1'b1;
  assign w_timeout    = r_illegal && !w_accept && (w_timer_inc == TO_MAX);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_warm       <= '0;
      r_cand       <= HALL_ILLEGAL_HI;
      r_accepted   <= HALL_ILLEGAL_HI;
      r_count      <= '0;
      r_values     <= HALL_ILLEGAL_HI;
      r_valid      <= 1'b0;
      r_changed    <= 1'b0;
      r_skip       <= 1'b0;
      r_have_legal <= 1'b0;
      r_illegal    <= 1'b0;
      r_timer      <= '0;
      r_fault      <= 1'b0;
      r_glitch     <= '0;
    end else begin
      if (!w_ready) r_warm <= r_warm + 1'b1;

      if (w_differ) begin
        r_cand  <= w_synced;
        r_count <= '0;
      end else if (w_ready && (r_count != DB_MAX)) begin
        r_count <= r_count + 1'b1;
      end

      if (w_glitch && (r_glitch != '1)) r_glitch <= r_glitch + 1'b1;

      r_changed <= w_changed;
      r_skip    <= w_skip;

      if (w_accept) begin
        r_accepted <= r_cand;
        r_timer    <= '0;
        r_valid    <= w_cand_legal;
        r_illegal  <= !w_cand_legal;
        if (w_cand_legal) begin
          r_values     <= r_cand;
          r_have_legal <= 1'b1;
        end
      end else if (r_illegal) begin
        r_timer <= w_timer_inc;
      end

      // A timeout set outranks a simultaneous clear.
      if (w_timeout)        r_fault <= 1'b1;
      else if (fault_clear) r_fault <= 1'b0;
    end
  end

  assign hall_values  = r_values;
  assign hall_valid   = r_valid;
  assign hall_changed = r_changed;
  assign hall_skip    = r_skip;
  assign hall_fault   = r_fault;
  assign glitch_count = r_glitch;

endmodule

// File: tb/tb_hall_input_filter.sv
// Directed bench for hall_input_filter: vector table plus hand-written corner sequences.
module tb_hall_input_filter;
  import hall_input_filter_pkg::*;

  localparam int SYNC = 2;
  localparam int DEB  = 4;
  localparam int TMO  = 8;
  localparam int GW   = 16;
  localparam int LAT  = SYNC + DEB + 1;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [2:0]    hall_raw = 3'b000;
  logic          fault_clear = 1'b0;
  hall_states_t  hall_values;
  logic          hall_valid, hall_changed, hall_skip, hall_fault;
  logic [GW-1:0] glitch_count;

  int checks = 0;
  int errors = 0;
  int n_chg, n_skip, chg_tick, skip_tick;

  typedef struct {
    logic [2:0] raw;
    int         cycles;
    logic [2:0] exp_val;
    logic       exp_valid;
    int         exp_chg_tick;
    int         exp_skip_tick;
    int         exp_glitch;
  } vec_t;

  vec_t vecs[14];

  always #5 clk = ~clk;

  hall_input_filter #(
    .clk_freq_hz           (27_000_000),
    .sync_stages           (SYNC),
    .debounce_ticks        (DEB),
    .invalid_timeout_ticks (TMO),
    .glitch_count_width    (GW)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .hall_raw     (hall_raw),
    .fault_clear  (fault_clear),
    .hall_values  (hall_values),
    .hall_valid   (hall_valid),
    .hall_changed (hall_changed),
    .hall_skip    (hall_skip),
    .hall_fault   (hall_fault),
    .glitch_count (glitch_count)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run(input logic [2:0] raw, input int n);
    hall_raw  = raw;
    n_chg     = 0;
    n_skip    = 0;
    chg_tick  = -1;
    skip_tick = -1;
    for (int i = 1; i <= n; i++) begin
      tick();
      if (hall_changed) begin n_chg++;  if (chg_tick < 0)  chg_tick = i;  end
      if (hall_skip)    begin n_skip++; if (skip_tick < 0) skip_tick = i; end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " values"},  int'(hall_values),  7);
    check({tag, " valid"},   int'(hall_valid),   0);
    check({tag, " changed"}, int'(hall_changed), 0);
    check({tag, " skip"},    int'(hall_skip),    0);
    check({tag, " fault"},   int'(hall_fault),   0);
    check({tag, " glitch"},  int'(glitch_count), 0);
  endtask

  initial begin
    vecs[0]  = '{3'b100,  2, 3'b101, 1'b1, -1, -1, 0};
    vecs[1]  = '{3'b101, 10, 3'b101, 1'b1, -1, -1, 1};
    vecs[2]  = '{3'b100,  2, 3'b101, 1'b1, -1, -1, 1};
    vecs[3]  = '{3'b101, 10, 3'b101, 1'b1, -1, -1, 2};
    vecs[4]  = '{3'b100,  2, 3'b101, 1'b1, -1, -1, 2};
    vecs[5]  = '{3'b101, 10, 3'b101, 1'b1, -1, -1, 3};
    vecs[6]  = '{3'b100,  2, 3'b101, 1'b1, -1, -1, 3};
    vecs[7]  = '{3'b101, 10, 3'b101, 1'b1, -1, -1, 4};
    vecs[8]  = '{3'b100, 10, 3'b100, 1'b1, LAT, -1, 4};
    vecs[9]  = '{3'b110, 10, 3'b110, 1'b1, LAT, -1, 4};
    vecs[10] = '{3'b010, 10, 3'b010, 1'b1, LAT, -1, 4};
    vecs[11] = '{3'b101, 10, 3'b101, 1'b1, LAT, LAT, 4};
    vecs[12] = '{3'b010, 10, 3'b010, 1'b1, LAT, LAT, 4};
    vecs[13] = '{3'b101, 10, 3'b101, 1'b1, LAT, LAT, 4};

    // Reset state, then first acceptance of 101
    tick();
    tick();
    check_reset_outputs("reset");
    reset_n  = 1'b1;
    hall_raw = 3'b101;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (i < LAT) begin
        check("first pre values", int'(hall_values), 7);
        check("first pre valid",  int'(hall_valid),  0);
      end else if (i == LAT) begin
        check("first values",  int'(hall_values),  5);
        check("first valid",   int'(hall_valid),   1);
        check("first changed", int'(hall_changed), 1);
        check("first skip",    int'(hall_skip),    0);
      end else begin
        check("first changed after", int'(hall_changed), 0);
      end
    end

    // Glitches, rotation and skips
    for (int v = 0; v < 14; v++) begin
      run(vecs[v].raw, vecs[v].cycles);
      check($sformatf("vec%0d values", v), int'(hall_values), int'(vecs[v].exp_val));
      check($sformatf("vec%0d valid", v),  int'(hall_valid),  int'(vecs[v].exp_valid));
      check($sformatf("vec%0d n_chg", v),  n_chg,  (vecs[v].exp_chg_tick  < 0) ? 0 : 1);
      check($sformatf("vec%0d n_skip", v), n_skip, (vecs[v].exp_skip_tick < 0) ? 0 : 1);
      check($sformatf("vec%0d chg_tick", v),  chg_tick,  vecs[v].exp_chg_tick);
      check($sformatf("vec%0d skip_tick", v), skip_tick, vecs[v].exp_skip_tick);
      check($sformatf("vec%0d glitch", v), int'(glitch_count), vecs[v].exp_glitch);
    end

    // Illegal 000 held after 101: hold values, drop valid, fault after timeout
    hall_raw = 3'b000;
    n_chg = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (hall_changed) n_chg++;
      if (i == LAT - 1) check("illegal pre valid", int'(hall_valid), 1);
      if (i == LAT) begin
        check("illegal valid",  int'(hall_valid),  0);
        check("illegal values", int'(hall_values), 5);
      end
      if (i == LAT + TMO - 1) check("fault pre", int'(hall_fault), 0);
      if (i == LAT + TMO)     check("fault set", int'(hall_fault), 1);
    end
    check("illegal no changed", n_chg, 0);
    fault_clear = 1'b1;
    tick();
    fault_clear = 1'b0;
    check("fault clear while illegal", int'(hall_fault), 1);
    tick();
    check("fault held while illegal", int'(hall_fault), 1);

    run(3'b101, 10);
    check("return valid",    int'(hall_valid),  1);
    check("return values",   int'(hall_values), 5);
    check("return no chg",   n_chg,  0);
    check("return no skip",  n_skip, 0);
    check("return fault",    int'(hall_fault),  1);
    check("return glitch",   int'(glitch_count), 4);
    fault_clear = 1'b1;
    tick();
    fault_clear = 1'b0;
    check("fault cleared", int'(hall_fault), 0);
    check("cleared valid", int'(hall_valid), 1);

    // Reset mid-debounce on 110, then fresh acceptance without skip
    hall_raw = 3'b110;
    tick();
    tick();
    tick();
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    tick();
    check_reset_outputs("midreset hold");
    reset_n = 1'b1;
    run(3'b110, 10);
    check("post reset values",   int'(hall_values), 6);
    check("post reset valid",    int'(hall_valid),  1);
    check("post reset chg_tick", chg_tick,  LAT);
    check("post reset n_chg",    n_chg,     1);
    check("post reset skip",     n_skip,    0);
    check("post reset glitch",   int'(glitch_count), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hall_input_filter.md
Name: hall_input_filter

Overview:
- Conditioning stage between the raw HALL sensor pins and three_phase_encoder.
- Synchronises the three asynchronous HALL inputs and debounces them with a stability counter.
- Rejects the illegal codes 3'b000 and 3'b111, flags skipped sectors, and raises a sticky fault when an illegal code persists.
- Output hall_values connects directly to the encoder's hall_values input.

Parameters:
- clk_freq_hz, 27_000_000: clock frequency in Hz; used only to derive the defaults below.
- sync_stages, 2: number of synchroniser flip-flops; legal range is 2 to 4.
- debounce_ticks, clk_freq_hz/1_000_000: number of consecutive cycles a code must be stable before it is accepted; minimum 1.
- invalid_timeout_ticks, clk_freq_hz/1_000: number of cycles an accepted-illegal code must persist before hall_fault is set.
- glitch_count_width, 16: width of the glitch counter.

Ports:
- clk, input, 1: system clock.
- reset_n, input, 1: reset, asynchronous and active-low.
- hall_raw, input, 3: unsynchronised sensor pins; bit2=A, bit1=B, bit0=C.
- fault_clear, input, 1: clears hall_fault (level-sensitive).
- hall_values, output, hall_states_t: last accepted legal code.
- hall_valid, output, 1: high while the current accepted code is legal.
- hall_changed, output, 1: one-cycle strobe when hall_values updates.
- hall_skip, output, 1: one-cycle strobe when the new code is not next()/prev() of the previous legal code.
- hall_fault, output, 1: sticky illegal-code timeout flag.
- glitch_count, output, glitch_count_width: saturating count of rejected short pulses.

Behaviour:
- Reset (asynchronous, all registers):
  - hall_values=3'b111, hall_valid=0; all strobes 0; hall_fault=0; glitch_count=0.
  - Synchroniser flops=0, candidate=3'b111, stable counter=0, invalid timer=0.
- Synchroniser: sync_stages-deep shift register per bit. The debouncer sees only its last stage.
- Candidate/stable counter:
  - If synced != candidate: candidate<=synced and counter<=0.
  - Otherwise counter increments, saturating at debounce_ticks.
- Acceptance: occurs on the edge where the counter reaches debounce_ticks-1 and candidate != accepted code.
- Latency: the first edge that samples the new raw value is edge 0. hall_values updates at edge sync_stages+debounce_ticks. hall_changed is high for the following cycle.
- Legal candidate accepted:
  - hall_values<=candidate, hall_valid<=1, hall_changed pulses.
  - hall_skip pulses in the same cycle if a previous legal code exists and the candidate is neither its next() nor its prev().
  - The first legal code after reset, or after an illegal period, compares against the last legal hall_values. The first code after reset never produces hall_skip.
- Illegal candidate (000/111) accepted:
  - hall_values holds its last legal value; hall_valid<=0; no hall_changed.
  - The invalid timer starts from 0.
- Invalid timer:
  - Counts while the accepted code is illegal, saturating.
  - On reaching invalid_timeout_ticks, hall_fault<=1.
  - Returning to a legal code clears the timer but not hall_fault.
- Fault clear:
  - fault_clear clears hall_fault on the next edge.
  - If set and clear coincide, set wins.
  - While an illegal code remains accepted past the timeout, the fault re-asserts every cycle.
- Glitch counting: when the candidate is replaced before acceptance, and that abandoned candidate differs from the accepted code, glitch_count increments by 1, saturating at all-ones.
- Raw input equal to the accepted code is never a glitch and never a change.
- Reset asserted mid-debounce: state returns to the reset values immediately; no strobe is emitted.

Decomposition:
- Shared types package, already holding hall_states_t with next()/prev():
  - Add constants HALL_ILLEGAL_LO=3'b000 and HALL_ILLEGAL_HI=3'b111.
  - Add function hall_is_legal().
  - Add function hall_is_adjacent(a,b).
- One natural sub-module, bit_synchronizer, parameterised by stage count and width, instantiated once with width 3.
- Debounce, validation and fault logic stay flat in hall_input_filter.

Test Plan (sync_stages=2, debounce_ticks=4, invalid_timeout_ticks=8 unless stated):
- Reset, then hold hall_raw=3'b101 from edge 0:
  - hall_values=3'b111 and hall_valid=0 until edge 6.
  - At edge 6: hall_values=3'b101, hall_valid=1.
  - hall_changed high exactly one cycle; hall_skip=0.
- Glitch: with 101 accepted, drive 100 for 2 cycles then back to 101 → hall_values stays 101, no strobe, glitch_count=1. Repeat 3 times → glitch_count=4.
- Rotation 101→100→110→010, each held 10 cycles → three hall_changed pulses, each 6 cycles after its raw change, hall_skip never asserted.
- Skip 101→010 → hall_values=010, hall_changed and hall_skip both pulse in the same cycle.
- Illegal 000 held 20 cycles after 101:
  - hall_valid=0 at acceptance; hall_values holds 101; hall_fault=1 eight cycles after acceptance.
  - fault_clear pulsed while 000 persists → hall_fault stays 1.
  - Return to 101, then fault_clear → hall_fault=0 and hall_valid=1. No hall_changed, because hall_values is unchanged.
- reset_n asserted at edge 3 of a debounce on 110 → outputs return to reset values at once. After release with hall_raw=110: hall_values=110 at edge 6 counted from the first post-reset sampling edge (edge 0), hall_skip=0.
